y86_pipe_reg: RTL



---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_pipe_reg_if.sv | 34 +++
 rtl/y86_pipe_reg_sat_counter.sv | 14 +
 rtl/y86_pipe_reg.sv | 76 +++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 PIPE definitions: status codes, icodes, control bundle
// and per-stage payload widths.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;

  // Stage payload widths (register IDs are 4 bits, data words 64 bits)
  localparam int F_PAYLOAD_W = 64;   // predPC
  localparam int D_PAYLOAD_W = 208;  // rA, rB, valC, valP plus sideband
  localparam int E_PAYLOAD_W = 208;  // valC, valA, valB, dstE, dstM, srcA, srcB
  localparam int M_PAYLOAD_W = 137;  // Cnd, valE, valA, dstE, dstM
  localparam int W_PAYLOAD_W = 136;  // valE, valM, dstE, dstM

  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
  } ctl_t;

  function automatic ctl_t bubble_ctl(input logic [2:0] bstat);
    ctl_t c;
    c.stat  = bstat;
    c.icode = I_NOP;
    c.ifun  = 4'h0;
    return c;
  endfunction

endpackage

// File: rtl/y86_pipe_reg_if.sv
// Bundle of upstream inputs, stall/bubble control and registered outputs
// of one pipeline stage register.
interface y86_pipe_reg_if #(
  parameter int PAYLOAD_W = 208,
  parameter int CNT_W     = 32
);
  logic [2:0]           in_stat;
  logic [3:0]           in_icode;
  logic [3:0]           in_ifun;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 stall;
  logic                 bubble;
  logic [2:0]           out_stat;
  logic [3:0]           out_icode;
  logic [3:0]           out_ifun;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_valid;
  logic                 ctl_conflict;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     bubble_cnt;

  // master: pipeline control / upstream stage; slave: the stage register
  modport master (
    output in_stat, in_icode, in_ifun, in_payload, stall, bubble,
    input  out_stat, out_icode, out_ifun, out_payload, out_valid,
           ctl_conflict, stall_cnt, bubble_cnt
  );

  modport slave (
    input  in_stat, in_icode, in_ifun, in_payload, stall, bubble,
    output out_stat, out_icode, out_ifun, out_payload, out_valid,
           ctl_conflict, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/y86_pipe_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/y86_pipe_reg.sv
// Y86-64 PIPE stage register with stall/bubble control, conflict flag and
// valid bit. Define PIPE_REG_PERF_EN for saturating stall/bubble counters.
module y86_pipe_reg
  import y86_pkg::*;
#(
  parameter int         PAYLOAD_W       = D_PAYLOAD_W,
  parameter bit         CLEAR_ON_BUBBLE = 1'b1,
  parameter logic [2:0] BUBBLE_STAT     = 3'd0,
  parameter int         CNT_W           = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  y86_pipe_reg_if.slave  pr
);
  ctl_t                 ctl_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 valid_q;
  logic                 conflict_q;

  // Stall takes priority over bubble; inputs are only sampled on a load,
  // so garbage on in_* during stall/bubble never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= bubble_ctl(BUBBLE_STAT);
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else if (pr.stall) begin
      ctl_q     <= ctl_q;
    end else if (pr.bubble) begin
      ctl_q     <= bubble_ctl(BUBBLE_STAT);
      valid_q   <= 1'b0;
      if (CLEAR_ON_BUBBLE) payload_q <= '0;
    end else begin
      ctl_q.stat  <= pr.in_stat;
      ctl_q.icode <= pr.in_icode;
      ctl_q.ifun  <= pr.in_ifun;
      payload_q   <= pr.in_payload;
      valid_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       conflict_q <= 1'b0;
    else if (pr.stall && pr.bubble)   conflict_q <= 1'b1;
  end

  assign pr.out_stat     = ctl_q.stat;
  assign pr.out_icode    = ctl_q.icode;
  assign pr.out_ifun     = ctl_q.ifun;
  assign pr.out_payload  = payload_q;
  assign pr.out_valid    = valid_q;
  assign pr.ctl_conflict = conflict_q;

`ifdef PIPE_REG_PERF_EN
  logic bubble_taken;
  assign bubble_taken = pr.bubble & ~pr.stall;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pr.stall),
    .cnt   (pr.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_taken),
    .cnt   (pr.bubble_cnt)
  );
`else
  assign pr.stall_cnt  = '0;
  assign pr.bubble_cnt = '0;
`endif

endmodule
